instr_fetch_queue: RTL

Instruction fetch stage directly upstream of the combinational instruction memory.
- Owns the fetch PC and drives the word address into the instruction memory.
- Captures the same-cycle read data into a small prefetch FIFO.
- Presents {pc, instr} pairs to decode over a valid/ready handshake.
- Branch redirects from execute flush the FIFO and restart fetch at the new target.

---
 rtl/instr_fetch_queue.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, addresses a zero-latency instruction
// memory, buffers {pc, instr} pairs in a small FIFO and hands them to decode over a
// valid/ready handshake. A redirect from execute flushes everything and restarts fetch.
//
// Optional build macro IFQ_SELF_LOOP_HALT_EN: when defined, fetching the self-branch
// word 32'hEAFFFFFE stops further enqueues (fetch_halted=1) until a redirect or reset.
// When undefined, fetch_halted is tied low and that word is treated like any other.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        fetch_halted
);

  // DEPTH is a power of two, so pointers wrap naturally at PtrW bits.
  localparam int unsigned     PtrW    = $clog2(DEPTH);
  // Occupancy must represent DEPTH itself, hence one extra code point.
  localparam int unsigned     CntW    = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];

  logic not_empty;
  logic full;
  logic deq;
  logic enq;
  logic halted;

  // Low address bits of a redirect target are discarded by design.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign imem_addr = fetch_pc_q;
  assign not_empty = (count_q != '0);
  assign full      = (count_q == FullCnt);

  // Redirect hides the head for the flush cycle so decode never consumes a stale entry.
  assign dec_valid = not_empty & ~redirect_valid;
  assign dec_pc    = not_empty ? pc_mem_q[rd_ptr_q]    : 32'h0;
  assign dec_instr = not_empty ? instr_mem_q[rd_ptr_q] : 32'h0;

  assign deq = dec_valid & dec_ready;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign enq = ~redirect_valid & ~halted & (~full | deq);

`ifdef IFQ_SELF_LOOP_HALT_EN
  localparam logic [31:0] SelfLoopWord = 32'hEAFF_FFFE;

  logic halted_q, halted_d;

  // Halt once the self-branch has been captured; only a redirect releases it.
  always_comb begin
    halted_d = halted_q;
    if (redirect_valid) begin
      halted_d = 1'b0;
    end else if (enq && (imem_rd == SelfLoopWord)) begin
      halted_d = 1'b1;
    end
  end

  // Halt flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign fetch_halted = halted;

  // Next-state for PC, pointers and occupancy; redirect overrides everything.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (enq) begin
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
        // Plain 32-bit add wraps 32'hFFFF_FFFC to 0.
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Entry storage; contents need no reset because count_q masks every stale slot.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rd;
    end
  end

`ifndef SYNTHESIS
  // Occupancy never exceeds the storage size.
  count_bound: assert property (@(posedge clk) disable iff (!reset_n) count_q <= FullCnt);

  // Fetch address stays word aligned.
  pc_aligned: assert property (@(posedge clk) disable iff (!reset_n) fetch_pc_q[1:0] == 2'b00);

  // Enqueue never overruns a full queue unless the head leaves too.
  no_overflow: assert property (@(posedge clk) disable iff (!reset_n) (enq && full) |-> deq);
`endif

endmodule
